// File: rtl/life_support_controller_if.sv
// rtl/life_support_controller_if.sv - telemetry/command bundle between plant side and supervisory controller
interface life_support_controller_if #(
    parameter int N = 32
);
    logic [N-1:0] shield;
    logic [N-1:0] temp;
    logic [N-1:0] pwr;
    logic [N-1:0] o2;
    logic         fatal;
    logic         threat;
    logic [3:0]   mode;
    logic         chrg;
    logic         o2sup;
    logic         alarm;
    logic [2:0]   state;

    modport master (
        output shield, temp, pwr, o2, fatal, threat,
        input  mode, chrg, o2sup, alarm, state
    );

    modport slave (
        input  shield, temp, pwr, o2, fatal, threat,
        output mode, chrg, o2sup, alarm, state
    );
endinterface

// File: rtl/life_support_controller.sv
// rtl/life_support_controller.sv - supervisory FSM with hysteresis and minimum dwell driving plant commands
module life_support_controller #(
    parameter int N        = 32,
    parameter int SH_LOW   = 50,
    parameter int SH_HIGH  = 100,
    parameter int PWR_LOW  = 20,
    parameter int PWR_HIGH = 200,
    parameter int O2_LOW   = 30,
    parameter int O2_HIGH  = 90,
    parameter int TEMP_HOT = 90,
    parameter int DWELL    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    life_support_controller_if.slave  bus
);
    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [2:0] {
        CRUISE   = 3'd0,
        DEFEND   = 3'd1,
        STEALTH  = 3'd2,
        RECHARGE = 3'd3,
        EMERG    = 3'd4
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    mode_q;
    logic          chrg_q;
    logic          o2sup_q;
    logic          alarm_q;

    logic dwell_done;
    logic pwr_low;
    logic pwr_full;
    logic shield_low;
    logic shield_full;
    logic hot;
    logic o2_low;
    logic o2_below_high;
    logic stealth_ok;

    assign dwell_done    = (cnt == CW'(DWELL));
    assign pwr_low       = (bus.pwr < N'(PWR_LOW));
    assign pwr_full      = (bus.pwr >= N'(PWR_HIGH));
    assign shield_low    = (bus.shield < N'(SH_LOW));
    assign shield_full   = (bus.shield >= N'(SH_HIGH));
    assign hot           = (bus.temp >= N'(TEMP_HOT));
    assign o2_low        = (bus.o2 < N'(O2_LOW));
    assign o2_below_high = (bus.o2 < N'(O2_HIGH));
    assign stealth_ok    = bus.threat && shield_low && !hot;

    // Next-state selection; branch order within each state encodes priority.
    always_comb begin
        nxt = cur;
        if (bus.fatal) begin
            nxt = EMERG;
        end else begin
            case (cur)
                EMERG: nxt = CRUISE;
                CRUISE: begin
                    if (pwr_low)         nxt = RECHARGE;
                    else if (stealth_ok) nxt = STEALTH;
                    else if (bus.threat) nxt = DEFEND;
                end
                DEFEND: begin
                    if (pwr_low)                                      nxt = RECHARGE;
                    else if (dwell_done && stealth_ok)                nxt = STEALTH;
                    else if (dwell_done && !bus.threat && shield_full) nxt = CRUISE;
                end
                STEALTH: begin
                    if (hot)                             nxt = DEFEND;
                    else if (pwr_low)                    nxt = RECHARGE;
                    else if (dwell_done && !bus.threat)  nxt = CRUISE;
                end
                RECHARGE: begin
                    if (dwell_done && pwr_full) nxt = CRUISE;
                end
                default: nxt = CRUISE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= CRUISE;
            cnt     <= '0;
            mode_q  <= 4'b0000;
            chrg_q  <= 1'b0;
            o2sup_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt != cur)      cnt <= '0;
            else if (!dwell_done) cnt <= cnt + CW'(1);

            case (nxt)
                DEFEND:  mode_q <= 4'b0100;
                STEALTH: mode_q <= 4'b1000;
                default: mode_q <= 4'b0000;
            endcase
            chrg_q  <= (nxt == RECHARGE) || (nxt == EMERG);
            // Supply latches on below O2_LOW and holds until O2_HIGH is reached.
            o2sup_q <= (nxt == EMERG) || o2_low || (o2sup_q && o2_below_high);
            alarm_q <= (nxt == EMERG) || o2_low;
        end
    end

    assign bus.state = cur;
    assign bus.mode  = mode_q;
    assign bus.chrg  = chrg_q;
    assign bus.o2sup = o2sup_q;
    assign bus.alarm = alarm_q;
endmodule

// File: tb/tb_life_support_controller.sv
// tb/tb_life_support_controller.sv - vector table, corner sequences and randomized model comparison
module tb_life_support_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    life_support_controller_if #(.N(32)) bus();

    life_support_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    int  m_state;
    int  m_cnt;
    bit  m_o2sup;
    bit  m_alarm;

    typedef struct {
        bit          rst;
        logic [31:0] shield, temp, pwr, o2;
        bit          fatal, threat;
        int          st, md;
        bit          ch, os, al;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int rule_next(int s, int c, int sh, int tp, int pw, bit f, bit th);
        bit done = (c >= 8);
        bit stealthy = th && sh < 50 && tp < 90;
        if (f) return 4;
        if (s == 4) return 0;
        if (s == 0) begin
            if (pw < 20) return 3;
            if (stealthy) return 2;
            if (th) return 1;
            return 0;
        end
        if (s == 1) begin
            if (pw < 20) return 3;
            if (done && stealthy) return 2;
            if (done && !th && sh >= 100) return 0;
            return 1;
        end
        if (s == 2) begin
            if (tp >= 90) return 1;
            if (pw < 20) return 3;
            if (done && !th) return 0;
            return 2;
        end
        if (s == 3) return (done && pw >= 200) ? 0 : 3;
        return 0;
    endfunction

    function automatic int mode_of(int s);
        return (s == 1) ? 4 : (s == 2) ? 8 : 0;
    endfunction

    task automatic model_edge();
        int ns;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_o2sup = 0; m_alarm = 0;
        end else begin
            ns = rule_next(m_state, m_cnt, int'(bus.shield), int'(bus.temp), int'(bus.pwr),
                           bus.fatal, bus.threat);
            m_cnt   = (ns != m_state) ? 0 : ((m_cnt < 8) ? m_cnt + 1 : 8);
            m_o2sup = (ns == 4) || (bus.o2 < 30) || (m_o2sup && bus.o2 < 90);
            m_alarm = (ns == 4) || (bus.o2 < 30);
            m_state = ns;
        end
    endtask

    task automatic drive(input bit r, input int sh, input int tp, input int pw, input int o,
                         input bit f, input bit th);
        rst = r; bus.shield = sh; bus.temp = tp; bus.pwr = pw; bus.o2 = o;
        bus.fatal = f; bus.threat = th;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic expect_out(input string name, input int st, input int md, input bit ch);
        check({name, ".state"}, {29'd0, bus.state}, st);
        check({name, ".mode"},  {28'd0, bus.mode}, md);
        check({name, ".chrg"},  {31'd0, bus.chrg}, ch);
    endtask

    vec_t vt[13];

    initial begin
        bus.shield = 0; bus.temp = 0; bus.pwr = 0; bus.o2 = 0; bus.fatal = 0; bus.threat = 0;
        m_state = 0; m_cnt = 0; m_o2sup = 0; m_alarm = 0;

        vt[0]  = '{1, 120, 50, 150,  0, 1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 120, 50, 150, 95, 0, 1, 1, 4, 0, 0, 0};
        vt[2]  = '{0, 120, 50, 150, 95, 0, 0, 1, 4, 0, 0, 0};
        vt[3]  = '{0, 120, 50,  20, 30, 0, 0, 1, 4, 0, 0, 0};
        vt[4]  = '{0, 120, 50,  19, 29, 0, 0, 3, 0, 1, 1, 1};
        vt[5]  = '{0, 120, 50,  19, 89, 0, 0, 3, 0, 1, 1, 0};
        vt[6]  = '{0, 120, 50,  19, 90, 0, 0, 3, 0, 1, 0, 0};
        vt[7]  = '{0, 120, 50,  19, 90, 1, 0, 4, 0, 1, 1, 1};
        vt[8]  = '{0, 120, 50, 150, 95, 0, 0, 0, 0, 0, 0, 0};
        vt[9]  = '{0,  49, 89, 150, 95, 0, 1, 2, 8, 0, 0, 0};
        vt[10] = '{0,  49, 90,  10, 95, 0, 1, 1, 4, 0, 0, 0};
        vt[11] = '{0,  49, 90,  10, 95, 0, 1, 3, 0, 1, 0, 0};
        vt[12] = '{1,  49, 90,  10,  0, 1, 1, 0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rst, vt[i].shield, vt[i].temp, vt[i].pwr, vt[i].o2,
                  vt[i].fatal, vt[i].threat);
            expect_out($sformatf("vec%0d", i), vt[i].st, vt[i].md, vt[i].ch);
            check($sformatf("vec%0d.o2sup", i), {31'd0, bus.o2sup}, vt[i].os);
            check($sformatf("vec%0d.alarm", i), {31'd0, bus.alarm}, vt[i].al);
        end

        // Defend dwell: entry edge, then 8 held edges, CRUISE on the next
        drive(0, 120, 50, 150, 95, 0, 1);
        expect_out("dwell_entry", 1, 4, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 120, 50, 150, 95, 0, 0);
            check($sformatf("dwell_hold%0d", i), {29'd0, bus.state}, 1);
        end
        drive(0, 120, 50, 150, 95, 0, 0);
        expect_out("dwell_exit", 0, 0, 0);

        // Stealth overheat abort
        drive(1, 0, 0, 150, 95, 0, 0);
        drive(0, 40, 50, 150, 95, 0, 1);
        expect_out("stealth_entry", 2, 8, 0);
        drive(0, 40, 50, 150, 95, 0, 1);
        drive(0, 40, 90, 150, 95, 0, 1);
        expect_out("stealth_hot", 1, 4, 0);

        // Recharge hysteresis
        drive(1, 120, 50, 150, 95, 0, 0);
        drive(0, 120, 50, 10, 95, 0, 0);
        expect_out("rech_entry", 3, 0, 1);
        for (int i = 0; i < 20; i++) drive(0, 120, 50, 199, 95, 0, 0);
        expect_out("rech_199", 3, 0, 1);
        drive(0, 120, 50, 200, 95, 0, 0);
        expect_out("rech_200", 0, 0, 0);

        // Emergency from STEALTH and recovery
        drive(0, 40, 50, 150, 95, 0, 1);
        drive(0, 40, 50, 150, 95, 1, 1);
        expect_out("emerg", 4, 0, 1);
        check("emerg.o2sup", {31'd0, bus.o2sup}, 1);
        check("emerg.alarm", {31'd0, bus.alarm}, 1);
        drive(0, 40, 50, 150, 95, 0, 0);
        expect_out("emerg_exit", 0, 0, 0);
        check("emerg_exit.o2sup", {31'd0, bus.o2sup}, 0);
        check("emerg_exit.alarm", {31'd0, bus.alarm}, 0);

        // Randomized run against the rule model
        drive(1, 0, 0, 150, 95, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  $urandom_range(30, 120), $urandom_range(70, 100),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : $urandom_range(150, 230),
                  $urandom_range(20, 100),
                  ($urandom_range(0, 39) == 0), $urandom_range(0, 1));
            check($sformatf("rnd%0d.state", i), {29'd0, bus.state}, m_state);
            check($sformatf("rnd%0d.mode", i), {28'd0, bus.mode}, mode_of(m_state));
            check($sformatf("rnd%0d.chrg", i), {31'd0, bus.chrg}, (m_state == 3 || m_state == 4));
            check($sformatf("rnd%0d.o2sup", i), {31'd0, bus.o2sup}, m_o2sup);
            check($sformatf("rnd%0d.alarm", i), {31'd0, bus.alarm}, m_alarm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
